// File: rtl/scene_renderer_pkg.sv
// Shared definitions for the scene renderer.
//  - Screen/sprite geometry localparams
//  - Game state encodings (S_START..S_LOSE)
//  - 24-bit {R,G,B} colour constants and the rgb_t type
//  - obj_snap_t: one object's per-frame snapshot (position, HP, flags)
package scene_renderer_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int SPRITE_W  = 32;
  localparam int SPRITE_H  = 64;
  localparam int BULLET_SZ = 8;
  localparam int HP_SEG_W  = 16;
  localparam int SHIELD_W  = 4;

  // HP bar rows and the horizontal margin of both bars.
  localparam int HP_ROW_LO = 8;
  localparam int HP_ROW_HI = 16;
  localparam int HP_MARGIN = 8;

  // START-screen box: half-open square of half-size 64 around the centre.
  localparam int BOX_HALF = 64;
  localparam int CENTRE_X = SCREEN_W / 2;
  localparam int CENTRE_Y = SCREEN_H / 2;

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_WIN   = 2'd2;
  localparam logic [1:0] S_LOSE  = 2'd3;

  typedef logic [23:0] rgb_t;

  localparam rgb_t RED_C     = 24'hFF0000;
  localparam rgb_t YELLOW_C  = 24'hFFFF00;
  localparam rgb_t CYAN_C    = 24'h00FFFF;
  localparam rgb_t BLUE_C    = 24'h0000FF;
  localparam rgb_t MAGENTA_C = 24'hFF00FF;
  localparam rgb_t GREEN_C   = 24'h00FF00;
  localparam rgb_t SKY_C     = 24'h87CEEB;
  localparam rgb_t WHITE_C   = 24'hFFFFFF;
  localparam rgb_t BLACK_C   = 24'h000000;

  typedef struct packed {
    logic signed [10:0] x;
    logic signed [9:0]  y;
    logic [1:0]         hp;
    logic               shield;
    logic               squat;
    logic               is_e;
  } obj_snap_t;

  // Character snapshot after reset: full HP, at origin, always present.
  localparam obj_snap_t CHAR_RESET = '{x: '0, y: '0, hp: 2'd3,
                                       shield: 1'b0, squat: 1'b0, is_e: 1'b1};

endpackage

// File: rtl/scene_renderer_rect_hit.sv
// Two-stage rectangle hit test.
//  Stage 1 registers dx = px - ox (12b signed) and dy = py - oy (11b signed).
//  Stage 2 registers:
//   hit_o : 0 <= dx < W and 0 <= dy < h, where h = H, or H/2 when half_i
//   ext_o : W <= dx < W+EXT on the same rows, when ext_en_i (e.g. a shield strip)
// Ports:
//  clk, rst            clock, synchronous active-high reset
//  px_i, py_i          unsigned pixel coordinate
//  ox_i, oy_i          signed object origin (top-left)
//  en_i                object present
//  half_i              use half height
//  ext_en_i            enable the right-hand extension strip
//  hit_o, ext_o        registered results, two cycles after the inputs
module scene_renderer_rect_hit #(
  parameter int W   = 32,
  parameter int H   = 64,
  parameter int EXT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [10:0]        px_i,
  input  logic [9:0]         py_i,
  input  logic signed [10:0] ox_i,
  input  logic signed [9:0]  oy_i,
  input  logic               en_i,
  input  logic               half_i,
  input  logic               ext_en_i,
  output logic               hit_o,
  output logic               ext_o
);

  localparam logic signed [11:0] W_L  = 12'(W);
  localparam logic signed [11:0] WE_L = 12'(W + EXT);
  localparam logic signed [10:0] H_L  = 11'(H);
  localparam logic signed [10:0] HH_L = 11'(H / 2);

  logic signed [11:0] dx_q, dx_d;
  logic signed [10:0] dy_q, dy_d;
  logic               en_q, half_q, ext_en_q;
  logic               hit_d, ext_d;
  logic               in_rows, in_cols, in_ext;

  // Pixel is zero-extended (unsigned), origin sign-extended.
  assign dx_d = $signed({1'b0, px_i}) - $signed({ox_i[10], ox_i});
  assign dy_d = $signed({1'b0, py_i}) - $signed({oy_i[9], oy_i});

  always_comb begin
    in_rows = (dy_q >= 11'sd0) && (dy_q < (half_q ? HH_L : H_L));
    in_cols = (dx_q >= 12'sd0) && (dx_q < W_L);
    in_ext  = (dx_q >= W_L) && (dx_q < WE_L);
    hit_d   = en_q && in_rows && in_cols;
    ext_d   = en_q && ext_en_q && in_rows && in_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dx_q     <= '0;
      dy_q     <= '0;
      en_q     <= 1'b0;
      half_q   <= 1'b0;
      ext_en_q <= 1'b0;
      hit_o    <= 1'b0;
      ext_o    <= 1'b0;
    end else begin
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      en_q     <= en_i;
      half_q   <= half_i;
      ext_en_q <= ext_en_i;
      hit_o    <= hit_d;
      ext_o    <= ext_d;
    end
  end

endmodule

// File: rtl/scene_renderer.sv
// Scene renderer: turns a per-frame game snapshot into per-pixel RGB.
//  Object/state inputs are captured only on i_frame_start, so a whole frame is
//  drawn from one coherent snapshot. Each pixel passes through a 3-stage
//  pipeline (S1 differences, S2 hit tests, S3 colour mux); o_valid/o_rgb appear
//  three cycles after i_valid/i_px/i_py. No backpressure.
// Ports:
//  clk, rst                      clock, synchronous active-high reset
//  i_frame_start                 capture snapshot this cycle
//  i_valid, i_px, i_py           pixel request
//  i_state                       START/PLAY/WIN/LOSE
//  i_player_*, i_enemy_*         character position/HP/shield/squat
//  i_goodbullet_*, i_badbullet_* bullet position and existence
//  o_valid, o_rgb                coloured pixel; o_rgb held during bubbles
module scene_renderer
  import scene_renderer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_frame_start,
  input  logic               i_valid,
  input  logic [10:0]        i_px,
  input  logic [9:0]         i_py,
  input  logic [1:0]         i_state,
  input  logic signed [10:0] i_player_x,
  input  logic signed [9:0]  i_player_y,
  input  logic [1:0]         i_player_hp,
  input  logic               i_player_shield,
  input  logic               i_player_squat,
  input  logic signed [10:0] i_enemy_x,
  input  logic signed [9:0]  i_enemy_y,
  input  logic [1:0]         i_enemy_hp,
  input  logic               i_enemy_shield,
  input  logic               i_enemy_squat,
  input  logic signed [10:0] i_goodbullet_x,
  input  logic signed [9:0]  i_goodbullet_y,
  input  logic               i_goodbullet_isE,
  input  logic signed [10:0] i_badbullet_x,
  input  logic signed [9:0]  i_badbullet_y,
  input  logic               i_badbullet_isE,
  output logic               o_valid,
  output rgb_t               o_rgb
);

  // ---------------- frame snapshot ----------------
  logic [1:0] state_q, state_d;
  obj_snap_t  player_q, player_d;
  obj_snap_t  enemy_q, enemy_d;
  obj_snap_t  gb_q, gb_d;
  obj_snap_t  bb_q, bb_d;

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    enemy_d  = enemy_q;
    gb_d     = gb_q;
    bb_d     = bb_q;
    if (i_frame_start) begin
      state_d  = i_state;
      player_d = '{x: i_player_x, y: i_player_y, hp: i_player_hp,
                   shield: i_player_shield, squat: i_player_squat, is_e: 1'b1};
      enemy_d  = '{x: i_enemy_x, y: i_enemy_y, hp: i_enemy_hp,
                   shield: i_enemy_shield, squat: i_enemy_squat, is_e: 1'b1};
      gb_d     = '{x: i_goodbullet_x, y: i_goodbullet_y, hp: 2'd0,
                   shield: 1'b0, squat: 1'b0, is_e: i_goodbullet_isE};
      bb_d     = '{x: i_badbullet_x, y: i_badbullet_y, hp: 2'd0,
                   shield: 1'b0, squat: 1'b0, is_e: i_badbullet_isE};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_START;
      player_q <= CHAR_RESET;
      enemy_q  <= CHAR_RESET;
      gb_q     <= '0;
      bb_q     <= '0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      enemy_q  <= enemy_d;
      gb_q     <= gb_d;
      bb_q     <= bb_d;
    end
  end

  // Bullet HP is never drawn; fold it away so it is not flagged as unused.
  logic unused_bullet_hp;
  assign unused_bullet_hp = ^{gb_q.hp, bb_q.hp};

  // ---------------- object hit tests (S1 + S2) ----------------
  // A squatting character keeps its bottom edge: shift the origin down by
  // half a sprite and test only half the height.
  localparam logic signed [9:0] SQUAT_OFS = 10'(SPRITE_H / 2);

  logic signed [9:0] p_oy, e_oy;
  assign p_oy = player_q.y + (player_q.squat ? SQUAT_OFS : 10'sd0);
  assign e_oy = enemy_q.y + (enemy_q.squat ? SQUAT_OFS : 10'sd0);

  logic p_hit, p_shield, e_hit, e_shield, gb_hit, bb_hit;
  logic gb_ext_unused, bb_ext_unused;

  scene_renderer_rect_hit #(.W(SPRITE_W), .H(SPRITE_H), .EXT(SHIELD_W)) u_player (
    .clk(clk), .rst(rst), .px_i(i_px), .py_i(i_py),
    .ox_i(player_q.x), .oy_i(p_oy), .en_i(player_q.is_e),
    .half_i(player_q.squat), .ext_en_i(player_q.shield),
    .hit_o(p_hit), .ext_o(p_shield)
  );

  scene_renderer_rect_hit #(.W(SPRITE_W), .H(SPRITE_H), .EXT(SHIELD_W)) u_enemy (
    .clk(clk), .rst(rst), .px_i(i_px), .py_i(i_py),
    .ox_i(enemy_q.x), .oy_i(e_oy), .en_i(enemy_q.is_e),
    .half_i(enemy_q.squat), .ext_en_i(enemy_q.shield),
    .hit_o(e_hit), .ext_o(e_shield)
  );

  scene_renderer_rect_hit #(.W(BULLET_SZ), .H(BULLET_SZ), .EXT(0)) u_goodbullet (
    .clk(clk), .rst(rst), .px_i(i_px), .py_i(i_py),
    .ox_i(gb_q.x), .oy_i(gb_q.y), .en_i(gb_q.is_e),
    .half_i(1'b0), .ext_en_i(1'b0),
    .hit_o(gb_hit), .ext_o(gb_ext_unused)
  );

  scene_renderer_rect_hit #(.W(BULLET_SZ), .H(BULLET_SZ), .EXT(0)) u_badbullet (
    .clk(clk), .rst(rst), .px_i(i_px), .py_i(i_py),
    .ox_i(bb_q.x), .oy_i(bb_q.y), .en_i(bb_q.is_e),
    .half_i(1'b0), .ext_en_i(1'b0),
    .hit_o(bb_hit), .ext_o(bb_ext_unused)
  );

  // ---------------- S1: pixel and per-pixel frame data ----------------
  logic        v1_q;
  logic [1:0]  st1_q;
  logic [10:0] px1_q;
  logic [9:0]  py1_q;
  logic [1:0]  php1_q, ehp1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      st1_q  <= S_START;
      px1_q  <= '0;
      py1_q  <= '0;
      php1_q <= '0;
      ehp1_q <= '0;
    end else begin
      v1_q   <= i_valid;
      st1_q  <= state_q;
      px1_q  <= i_px;
      py1_q  <= i_py;
      php1_q <= player_q.hp;
      ehp1_q <= enemy_q.hp;
    end
  end

  // ---------------- S2: HP bar and START box ----------------
  logic [11:0] p_bar_end, e_bar_reach;
  logic        hp_rows, hp_d, box_d;

  // Player bar grows right from HP_MARGIN; enemy bar grows left from
  // SCREEN_W-HP_MARGIN. Comparing px+len against the right end avoids a
  // subtraction that could underflow.
  assign p_bar_end   = 12'(HP_MARGIN) + {6'd0, php1_q, 4'd0};
  assign e_bar_reach = {1'b0, px1_q} + {6'd0, ehp1_q, 4'd0};

  always_comb begin
    hp_rows = (py1_q >= 10'(HP_ROW_LO)) && (py1_q < 10'(HP_ROW_HI));
    hp_d    = hp_rows &&
              ((({1'b0, px1_q} >= 12'(HP_MARGIN)) && ({1'b0, px1_q} < p_bar_end)) ||
               ((e_bar_reach >= 12'(SCREEN_W - HP_MARGIN)) &&
                (px1_q < 11'(SCREEN_W - HP_MARGIN))));
    box_d   = (px1_q >= 11'(CENTRE_X - BOX_HALF)) && (px1_q < 11'(CENTRE_X + BOX_HALF)) &&
              (py1_q >= 10'(CENTRE_Y - BOX_HALF)) && (py1_q < 10'(CENTRE_Y + BOX_HALF));
  end

  logic       v2_q, hp2_q, box2_q;
  logic [1:0] st2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q   <= 1'b0;
      st2_q  <= S_START;
      hp2_q  <= 1'b0;
      box2_q <= 1'b0;
    end else begin
      v2_q   <= v1_q;
      st2_q  <= st1_q;
      hp2_q  <= hp_d;
      box2_q <= box_d;
    end
  end

  // ---------------- S3: priority colour mux ----------------
  rgb_t rgb_d;

  always_comb begin
    rgb_d = SKY_C;
    case (st2_q)
      S_START: rgb_d = box2_q ? WHITE_C : BLACK_C;
      S_WIN:   rgb_d = GREEN_C;
      S_LOSE:  rgb_d = RED_C;
      default: begin
        if (bb_hit)                     rgb_d = RED_C;
        else if (gb_hit)                rgb_d = YELLOW_C;
        else if (p_shield || e_shield)  rgb_d = CYAN_C;
        else if (p_hit)                 rgb_d = BLUE_C;
        else if (e_hit)                 rgb_d = MAGENTA_C;
        else if (hp2_q)                 rgb_d = GREEN_C;
        else                            rgb_d = SKY_C;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_rgb   <= '0;
    end else begin
      o_valid <= v2_q;
      if (v2_q) o_rgb <= rgb_d;
    end
  end

endmodule

// File: tb/tb_scene_renderer.sv
module tb_scene_renderer;

  typedef struct {
    int x;
    int y;
    int hp;
    int sh;
    int sq;
    int e;
  } obj_t;

  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_GREEN   = 24'h00FF00;
  localparam logic [23:0] C_SKY     = 24'h87CEEB;
  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_BLACK   = 24'h000000;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               i_frame_start = 1'b0, i_valid = 1'b0;
  logic [10:0]        i_px = '0;
  logic [9:0]         i_py = '0;
  logic [1:0]         i_state = '0;
  logic signed [10:0] i_player_x = '0, i_enemy_x = '0, i_goodbullet_x = '0, i_badbullet_x = '0;
  logic signed [9:0]  i_player_y = '0, i_enemy_y = '0, i_goodbullet_y = '0, i_badbullet_y = '0;
  logic [1:0]         i_player_hp = '0, i_enemy_hp = '0;
  logic               i_player_shield = 1'b0, i_player_squat = 1'b0;
  logic               i_enemy_shield = 1'b0, i_enemy_squat = 1'b0;
  logic               i_goodbullet_isE = 1'b0, i_badbullet_isE = 1'b0;
  logic               o_valid;
  logic [23:0]        o_rgb;

  scene_renderer dut (
    .clk(clk), .rst(rst), .i_frame_start(i_frame_start), .i_valid(i_valid),
    .i_px(i_px), .i_py(i_py), .i_state(i_state),
    .i_player_x(i_player_x), .i_player_y(i_player_y), .i_player_hp(i_player_hp),
    .i_player_shield(i_player_shield), .i_player_squat(i_player_squat),
    .i_enemy_x(i_enemy_x), .i_enemy_y(i_enemy_y), .i_enemy_hp(i_enemy_hp),
    .i_enemy_shield(i_enemy_shield), .i_enemy_squat(i_enemy_squat),
    .i_goodbullet_x(i_goodbullet_x), .i_goodbullet_y(i_goodbullet_y),
    .i_goodbullet_isE(i_goodbullet_isE),
    .i_badbullet_x(i_badbullet_x), .i_badbullet_y(i_badbullet_y),
    .i_badbullet_isE(i_badbullet_isE),
    .o_valid(o_valid), .o_rgb(o_rgb)
  );

  // ---------------- reference model (frame snapshot + pixel rules) ----------------
  int   m_st;
  obj_t m_p, m_e, m_g, m_b;

  function automatic bit in_rect(int x, int y, int ox, int oy, int w, int h);
    return (x >= ox) && (x < ox + w) && (y >= oy) && (y < oy + h);
  endfunction

  // A squatting character occupies the lower half of its standing box.
  function automatic bit body_at(obj_t o, int x, int y);
    return in_rect(x, y, o.x, o.y + (o.sq != 0 ? 32 : 0), 32, o.sq != 0 ? 32 : 64);
  endfunction

  function automatic bit shield_at(obj_t o, int x, int y);
    return (o.sh != 0) && in_rect(x, y, o.x + 32, o.y + (o.sq != 0 ? 32 : 0), 4, o.sq != 0 ? 32 : 64);
  endfunction

  function automatic logic [23:0] model_rgb(int x, int y);
    if (m_st == 0) return (x >= 256 && x < 384 && y >= 176 && y < 304) ? C_WHITE : C_BLACK;
    if (m_st == 2) return C_GREEN;
    if (m_st == 3) return C_RED;
    if (m_b.e != 0 && in_rect(x, y, m_b.x, m_b.y, 8, 8)) return C_RED;
    if (m_g.e != 0 && in_rect(x, y, m_g.x, m_g.y, 8, 8)) return C_YELLOW;
    if (shield_at(m_p, x, y) || shield_at(m_e, x, y)) return C_CYAN;
    if (body_at(m_p, x, y)) return C_BLUE;
    if (body_at(m_e, x, y)) return C_MAGENTA;
    if (y >= 8 && y < 16 &&
        ((x >= 8 && x < 8 + 16 * m_p.hp) || (x >= 632 - 16 * m_e.hp && x < 632)))
      return C_GREEN;
    return C_SKY;
  endfunction

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [2:0]  vhist = '0;

  // Requested-valid history: o_valid must equal i_valid from three cycles back.
  always @(posedge clk) begin
    if (rst) vhist = '0;
    else     vhist = {vhist[1:0], i_valid};
  end

  always @(negedge clk) begin
    checks++;
    if (o_valid !== vhist[2]) begin
      failures++;
      $display("FAIL valid_latency t=%0t got=%b exp=%b", $time, o_valid, vhist[2]);
    end
    if (o_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pixel t=%0t got=%h exp=none", $time, o_rgb);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if (o_rgb !== e) begin
          failures++;
          $display("FAIL pixel_rgb t=%0t got=%h exp=%h", $time, o_rgb, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic obj_t mk(int x, int y, int hp, int sh, int sq, int e);
    obj_t o;
    o.x = x; o.y = y; o.hp = hp; o.sh = sh; o.sq = sq; o.e = e;
    return o;
  endfunction

  task automatic drive_snap(input int st, input obj_t p, input obj_t e, input obj_t g, input obj_t b);
    i_state          = 2'(st);
    i_player_x       = 11'(p.x);  i_player_y = 10'(p.y);  i_player_hp = 2'(p.hp);
    i_player_shield  = p.sh[0];   i_player_squat = p.sq[0];
    i_enemy_x        = 11'(e.x);  i_enemy_y = 10'(e.y);   i_enemy_hp = 2'(e.hp);
    i_enemy_shield   = e.sh[0];   i_enemy_squat = e.sq[0];
    i_goodbullet_x   = 11'(g.x);  i_goodbullet_y = 10'(g.y); i_goodbullet_isE = g.e[0];
    i_badbullet_x    = 11'(b.x);  i_badbullet_y = 10'(b.y);  i_badbullet_isE = b.e[0];
  endtask

  task automatic frame(input int st, input obj_t p, input obj_t e, input obj_t g, input obj_t b);
    drive_snap(st, p, e, g, b);
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    m_st = st; m_p = p; m_e = e; m_g = g; m_b = b;
  endtask

  task automatic pix(input int x, input int y);
    i_valid = 1'b1;
    i_px    = 11'(x);
    i_py    = 10'(y);
    exp_q.push_back(model_rgb(x, y));
    step();
    i_valid = 1'b0;
  endtask

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic obj_t rnd_char();
    return mk(int'($urandom_range(0, 700)) - 40, int'($urandom_range(0, 570)) - 100,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), 1);
  endfunction

  function automatic obj_t rnd_bullet(obj_t near);
    return mk(near.x + int'($urandom_range(0, 40)) - 8, clampi(near.y + int'($urandom_range(0, 70)) - 8, -100, 470),
              0, 0, 0, int'($urandom_range(0, 1)));
  endfunction

  // ---------------- main sequence ----------------
  obj_t none_o, far_e, p0, bb0;

  initial begin
    // Model mirrors the reset snapshot.
    m_st = 0;
    m_p = mk(0, 0, 3, 0, 0, 1);
    m_e = mk(0, 0, 3, 0, 0, 1);
    m_g = mk(0, 0, 0, 0, 0, 0);
    m_b = mk(0, 0, 0, 0, 0, 0);
    none_o = mk(0, 0, 0, 0, 0, 0);
    far_e  = mk(500, 300, 3, 0, 0, 1);

    rst = 1'b1;
    idle(3);
    checks++;
    if (o_valid !== 1'b0 || o_rgb !== 24'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%b/%h exp=0/000000", o_valid, o_rgb);
    end
    rst = 1'b0;
    idle(1);

    // START screen, from the reset snapshot and after an explicit START frame.
    pix(320, 240); pix(0, 0);
    frame(0, mk(0, 0, 3, 0, 0, 1), mk(0, 0, 3, 0, 0, 1), none_o, none_o);
    pix(320, 240); pix(0, 0); pix(255, 240); pix(256, 176); pix(383, 303); pix(384, 303);
    frame(2, far_e, far_e, none_o, none_o); pix(10, 10);
    frame(3, far_e, far_e, none_o, none_o); pix(10, 10);

    // PLAY, standing player.
    p0 = mk(100, 200, 3, 0, 0, 1);
    frame(1, p0, far_e, none_o, none_o);
    pix(100, 200); pix(131, 263); pix(132, 200); pix(100, 264); pix(500, 300); pix(531, 363);

    // Squat: upper half vanishes.
    p0.sq = 1;
    frame(1, p0, far_e, none_o, none_o);
    pix(100, 220); pix(100, 232); pix(131, 263); pix(100, 231);

    // Shield strip right of the character.
    p0.sh = 1;
    frame(1, p0, far_e, none_o, none_o);
    pix(132, 240); pix(135, 263); pix(136, 240); pix(132, 220);
    p0.sh = 0; p0.sq = 0;

    // Bad bullet over the player; then non-existent.
    bb0 = mk(110, 210, 0, 0, 0, 1);
    frame(1, p0, far_e, none_o, bb0);
    pix(112, 212); pix(117, 217); pix(118, 212);
    bb0.e = 0;
    frame(1, p0, far_e, mk(110, 210, 0, 0, 0, 1), bb0);
    pix(112, 212);
    frame(1, p0, far_e, none_o, bb0);
    pix(112, 212);

    // Partially off-screen player.
    frame(1, mk(-20, 200, 3, 0, 0, 1), far_e, none_o, none_o);
    pix(0, 200); pix(11, 263); pix(12, 200); pix(619, 200); pix(639, 200);

    // HP bars: player hp 3 / 0, enemy hp 2.
    frame(1, mk(100, 200, 3, 0, 0, 1), mk(500, 300, 2, 0, 0, 1), none_o, none_o);
    pix(8, 8); pix(55, 15); pix(56, 10); pix(7, 10); pix(8, 16);
    pix(600, 10); pix(631, 10); pix(599, 10); pix(632, 10);
    frame(1, mk(100, 200, 0, 0, 0, 1), mk(500, 300, 0, 0, 0, 1), none_o, none_o);
    pix(10, 10); pix(620, 10);

    // Mid-frame input change without frame_start has no effect; gaps propagate.
    frame(1, p0, far_e, none_o, none_o);
    i_player_x = 11'sd300;
    pix(100, 200); idle(2); pix(131, 263); pix(300, 200);
    // Pixel issued in the same cycle as frame_start uses the old snapshot.
    drive_snap(1, mk(300, 200, 3, 0, 0, 1), far_e, none_o, none_o);
    i_frame_start = 1'b1;
    pix(100, 200);
    i_frame_start = 1'b0;
    m_p = mk(300, 200, 3, 0, 0, 1);
    pix(100, 200); pix(300, 200);
    idle(4);

    // Randomised frames, pixels biased around the objects.
    for (int f = 0; f < 12; f++) begin
      obj_t rp, re;
      int   st;
      st = int'($urandom_range(0, 7));
      if (st > 3) st = 1;
      rp = rnd_char();
      re = rnd_char();
      frame(st, rp, re, rnd_bullet(rp), rnd_bullet($urandom_range(0, 1) != 0 ? rp : re));
      for (int k = 0; k < 120; k++) begin
        int x, y, sel;
        sel = int'($urandom_range(0, 3));
        if (sel == 0) begin
          x = int'($urandom_range(0, 639)); y = int'($urandom_range(0, 479));
        end else if (sel == 3) begin
          x = int'($urandom_range(0, 639)); y = int'($urandom_range(6, 17));
        end else begin
          obj_t o;
          o = (sel == 1) ? m_p : m_e;
          x = clampi(o.x + int'($urandom_range(0, 44)) - 4, 0, 639);
          y = clampi(o.y + int'($urandom_range(0, 72)) - 4, 0, 479);
        end
        pix(x, y);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d_pending exp=0_pending", exp_q.size());
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
